// File: rtl/spi_master_fifo_if.sv
// Host-side bundle of the FIFO-fed SPI master.
// master = host logic, slave = spi_master_fifo.
interface spi_master_fifo_if #(
  parameter int DATA_W   = 8,
  parameter int RX_WORDS = 15
);
  logic [DATA_W-1:0]          Data_in;
  logic                       Data_available;
  logic                       Read_request;
  logic [RX_WORDS*DATA_W-1:0] Data_out;
  logic                       rx_valid;
  logic                       tx_full;
  logic                       tx_empty;
  logic                       tx_drop;
  logic                       busy;

  modport master (
    output Data_in, Data_available, Read_request,
    input  Data_out, rx_valid, tx_full, tx_empty,
    input  tx_drop, busy
  );

  modport slave (
    input  Data_in, Data_available, Read_request,
    output Data_out, rx_valid, tx_full, tx_empty,
    output tx_drop, busy
  );
endinterface

// File: rtl/spi_master_fifo.sv
// SPI master with TX FIFO, multi-word read frames,
// selectable CPOL/CPHA and fixed SCLK divider.
module spi_master_fifo #(
  parameter int DATA_W   = 8,
  parameter int TX_DEPTH = 4,
  parameter int RX_WORDS = 15,
  parameter int CLK_DIV  = 10,
  parameter bit CPOL     = 1'b0,
  parameter bit CPHA     = 1'b0,
  parameter int CS_GAP   = 2
) (
  input  logic        Mclk,
  input  logic        nReset,
  spi_master_fifo_if.slave host,
  input  logic        spi_miso,
  output logic        spi_clk,
  output logic        spi_cs,
  output logic        spi_mosi
);
  localparam int NBR  = RX_WORDS * DATA_W;
  localparam int AW   = $clog2(TX_DEPTH);
  localparam int AW1  = AW + 1;
  localparam int EW   = $clog2(2 * NBR + 1);
  localparam int GAPC = CS_GAP * CLK_DIV;
  localparam int CW   = $clog2(GAPC + CLK_DIV + 1);

  localparam logic [AW:0]   DEPTH   = AW1'(TX_DEPTH);
  localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_END = CW'(GAPC - 1);
  localparam logic [EW-1:0] E_RD_L  = EW'(2 * NBR - 1);
  localparam logic [EW-1:0] E_WR_L  = EW'(2 * DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, GAP
  } state_t;

  state_t state, state_n;

  logic              da_q, rr_q, pend;
  logic [DATA_W-1:0] mem [TX_DEPTH];
  logic [DATA_W-1:0] head;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [CW-1:0]     cnt, limit;
  logic [EW-1:0]     edges;
  logic              rd_frame;
  logic [DATA_W-1:0] tx_sr;
  logic [NBR-1:0]    rx_sr;
  logic              push, pop, wr_en, full, empty;
  logic              phase_end, last_edge, lead;

  assign push  = host.Data_available & ~da_q;
  assign full  = count == DEPTH;
  assign empty = count == '0;
  assign pop   = state == IDLE && !pend && !empty;
  assign wr_en = push && (!full || pop);
  assign head  = mem[rd_ptr];

  assign host.tx_full  = full;
  assign host.tx_empty = empty;
  assign host.busy     = state != IDLE;

  assign limit     = state == GAP ? GAP_END : DIV_END;
  assign phase_end = cnt == limit;
  assign lead      = ~edges[0];
  assign last_edge = edges == (rd_frame ? E_RD_L : E_WR_L);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (pend || !empty) state_n = SETUP;
      SETUP: if (phase_end) state_n = SHIFT;
      SHIFT: if (phase_end && last_edge) state_n = HOLD;
      HOLD:  if (phase_end) state_n = GAP;
      GAP:   if (phase_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Mclk or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge Mclk) begin
    if (wr_en) mem[wr_ptr] <= host.Data_in;
  end

  always_ff @(posedge Mclk or negedge nReset) begin
    if (!nReset) begin
      da_q         <= 1'b0;
      rr_q         <= 1'b0;
      pend         <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      host.tx_drop <= 1'b0;
    end else begin
      da_q         <= host.Data_available;
      rr_q         <= host.Read_request;
      host.tx_drop <= push && full && !pop;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + AW1'(wr_en) - AW1'(pop);
      // a strobe while the request is still queued is dropped
      if (state == IDLE && pend)
        pend <= 1'b0;
      else if (host.Read_request && !rr_q)
        pend <= 1'b1;
    end
  end

  always_ff @(posedge Mclk or negedge nReset) begin
    if (!nReset) begin
      cnt           <= '0;
      edges         <= '0;
      rd_frame      <= 1'b0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      spi_clk       <= CPOL;
      spi_cs        <= 1'b1;
      spi_mosi      <= 1'b0;
      host.Data_out <= '0;
      host.rx_valid <= 1'b0;
    end else begin
      host.rx_valid <= 1'b0;
      if (state == IDLE || phase_end) cnt <= '0;
      else                            cnt <= cnt + 1'b1;
      unique case (state)
        IDLE: if (pend || !empty) begin
          spi_cs   <= 1'b0;
          edges    <= '0;
          rd_frame <= pend;
          if (pend) begin
            tx_sr    <= '0;
            spi_mosi <= 1'b0;
          end else if (CPHA) begin
            tx_sr    <= head;
            spi_mosi <= 1'b0;
          end else begin
            tx_sr    <= head << 1;
            spi_mosi <= head[DATA_W-1];
          end
        end
        SHIFT: if (phase_end) begin
          spi_clk <= ~spi_clk;
          edges   <= edges + 1'b1;
          // launch edge vs capture edge depends on CPHA
          if (lead == CPHA) begin
            spi_mosi <= tx_sr[DATA_W-1];
            tx_sr    <= tx_sr << 1;
          end else if (rd_frame) begin
            rx_sr <= {rx_sr[NBR-2:0], spi_miso};
          end
        end
        HOLD: if (phase_end) begin
          spi_cs   <= 1'b1;
          spi_mosi <= 1'b0;
          if (rd_frame) begin
            host.Data_out <= rx_sr;
            host.rx_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
